// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester main-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef enum logic {REQ_I = 1'b0, REQ_D = 1'b1} req_id_t;

  localparam int BYTES = 4;

  // Byte [0] sits in the most significant position of the packed word.
  typedef logic [0:BYTES-1][7:0] word_bytes_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the side that was not served last wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic    i_req_i,
  input  logic    i_req_d,
  input  req_id_t i_last_grant,
  output logic    o_grant_valid,
  output req_id_t o_grant_id
);

  always_comb begin
    o_grant_valid = i_req_i | i_req_d;
    o_grant_id    = REQ_I;
    if (i_req_i && i_req_d) begin
      o_grant_id = (i_last_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (i_req_d) begin
      o_grant_id = REQ_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between an instruction-fetch reader and a
// data-cache reader/writer; a grant is held for the whole transaction.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output word_bytes_t       i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  word_bytes_t       d_wdata,
  output word_bytes_t       d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_addr,
  output word_bytes_t       mem_data_in,
  input  word_bytes_t       mem_data_out,
  output logic              mem_write_en,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  req_id_t          r_last_grant;
  req_id_t          r_owner;
  logic             r_we;
  logic             w_grant_valid;
  req_id_t          w_grant_id;
  logic             w_take_grant;

  rr_pick2 u_pick (
    .i_req_i       (i_req),
    .i_req_d       (d_req),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  assign w_take_grant = (r_state == IDLE) && w_grant_valid;
  assign busy         = (r_state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant_valid) w_next_state = ACCESS;
      ACCESS:  if (r_cnt == '0) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Memory-side signals are latched at grant and held; done is a single-cycle
  // pulse raised on the last ACCESS edge and dropped on the following one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_last_grant <= REQ_I;
      r_owner      <= REQ_I;
      r_we         <= 1'b0;
      mem_addr     <= '0;
      mem_data_in  <= '0;
      mem_write_en <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      if (w_take_grant) begin
        r_owner      <= w_grant_id;
        r_last_grant <= w_grant_id;
        r_cnt        <= CNT_LOAD;
        if (w_grant_id == REQ_D) begin
          r_we         <= d_we;
          mem_addr     <= d_addr;
          mem_data_in  <= d_wdata;
          mem_write_en <= d_we;
        end else begin
          r_we         <= 1'b0;
          mem_addr     <= i_addr;
          mem_data_in  <= '0;
          mem_write_en <= 1'b0;
        end
      end else if (r_state == ACCESS) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end else begin
          mem_write_en <= 1'b0;
          if (r_owner == REQ_D) begin
            d_done <= 1'b1;
            if (!r_we) d_rdata <= mem_data_out;
          end else begin
            i_done  <= 1'b1;
            i_rdata <= mem_data_out;
          end
        end
      end
    end
  end

endmodule
